// File: rtl/handwrite_canvas_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : handwrite_canvas_pkg                                         |
// | Purpose  : Shared types and helpers for the handwriting capture canvas:  |
// |            top-level state encoding, brush shape selector values,        |
// |            mouse packet width and the row-major cell index function.     |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
package handwrite_canvas_pkg;

   // Top-level operating state: drawing with the mouse, or streaming pixels.
   typedef enum logic [0:0] {
      ST_DRAW   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   // Brush shape selector value for the plus-shaped brush.
   localparam int BRUSH_SHAPE_PLUS = 1;

   // Width of a PS/2 relative motion field (9-bit two's complement).
   localparam int MOVE_W = 9;

   // Row-major bit index of cell (x, y) in a canvas that is w cells wide.
   function automatic int unsigned cell_index(input int unsigned x,
                                              input int unsigned y,
                                              input int unsigned w);
      return y * w + x;
   endfunction

endpackage
`default_nettype wire

// File: rtl/handwrite_canvas_mouse_axis_accum.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : mouse_axis_accum                                             |
// | Purpose  : One axis of the cursor. Holds a fixed-point position with     |
// |            SCALE_SHIFT fraction bits, adds (or subtracts when INVERT)    |
// |            the sign-extended mouse delta, and clamps to the canvas.      |
// | Ports    : clk, rst      clock / synchronous active-high reset           |
// |            i_en          apply i_delta on this edge                      |
// |            i_delta       signed motion count                             |
// |            o_cursor      registered integer cell coordinate              |
// |            o_cursor_next coordinate the next edge will load              |
// | Revision : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
module mouse_axis_accum
   import handwrite_canvas_pkg::*;
#(
   parameter int N           = 30,
   parameter int SCALE_SHIFT = 2,
   parameter int INVERT      = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_en,
   input  logic signed [MOVE_W-1:0] i_delta,
   output logic [$clog2(N)-1:0]     o_cursor,
   output logic [$clog2(N)-1:0]     o_cursor_next
);

   localparam int POS_W = $clog2(N) + SCALE_SHIFT;
   // Headroom so position +/- any 9-bit delta never overflows the sum.
   localparam int SUM_W = POS_W + MOVE_W + 2;

   localparam logic [POS_W-1:0]        POS_MAX = POS_W'((N << SCALE_SHIFT) - 1);
   localparam logic [POS_W-1:0]        POS_RST = POS_W'((N / 2) << SCALE_SHIFT);
   localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'((N << SCALE_SHIFT) - 1);

   logic [POS_W-1:0]        pos_q, pos_d;
   logic signed [SUM_W-1:0] pos_ext, delta_ext, sum;

   always_comb begin
      pos_ext   = $signed({{(SUM_W-POS_W){1'b0}}, pos_q});
      delta_ext = SUM_W'(i_delta);
      // Screen y grows downward while mouse dy is positive upward.
      if (INVERT != 0) begin
         sum = pos_ext - delta_ext;
      end else begin
         sum = pos_ext + delta_ext;
      end

      pos_d = pos_q;
      if (i_en) begin
         if (sum[SUM_W-1]) begin
            pos_d = '0;
         end else if (sum > SUM_MAX) begin
            pos_d = POS_MAX;
         end else begin
            pos_d = sum[POS_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pos_q <= POS_RST;
      end else begin
         pos_q <= pos_d;
      end
   end

   assign o_cursor      = pos_q[POS_W-1:SCALE_SHIFT];
   assign o_cursor_next = pos_d[POS_W-1:SCALE_SHIFT];

endmodule
`default_nettype wire

// File: rtl/handwrite_canvas.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : handwrite_canvas                                             |
// | Purpose  : Mouse-driven handwriting canvas. Tracks a clamped cursor from |
// |            PS/2 relative motion, paints/erases cells with a single or    |
// |            plus-shaped brush, exposes the bitmap flat, and on submit     |
// |            streams it row-major as PIXEL_W-bit pixels (valid/ready).     |
// | Ports    : clk, rst                 clock / sync active-high reset       |
// |            i_mouse_valid, i_move_x, i_move_y, i_lmb, i_rmb  mouse packet |
// |            i_clear, i_submit        clear canvas / start stream pulses   |
// |            i_pixel_ready            downstream ready                     |
// |            o_pixel, o_pixel_valid   streamed pixel and its valid         |
// |            o_stream_done            pulse after the last pixel accepted  |
// |            o_busy                   streaming in progress                |
// |            o_cursor_x, o_cursor_y   cursor cell (row 0 = top)            |
// |            o_canvas                 bitmap, bit y*CANVAS_W+x             |
// | Revision : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
module handwrite_canvas
   import handwrite_canvas_pkg::*;
#(
   parameter int CANVAS_W    = 30,
   parameter int CANVAS_H    = 30,
   parameter int SCALE_SHIFT = 2,
   parameter int PIXEL_W     = 8,
   parameter int BRUSH_PLUS  = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_mouse_valid,
   input  logic [MOVE_W-1:0]             i_move_x,
   input  logic [MOVE_W-1:0]             i_move_y,
   input  logic                          i_lmb,
   input  logic                          i_rmb,
   input  logic                          i_clear,
   input  logic                          i_submit,
   input  logic                          i_pixel_ready,
   output logic [PIXEL_W-1:0]            o_pixel,
   output logic                          o_pixel_valid,
   output logic                          o_stream_done,
   output logic                          o_busy,
   output logic [$clog2(CANVAS_W)-1:0]   o_cursor_x,
   output logic [$clog2(CANVAS_H)-1:0]   o_cursor_y,
   output logic [CANVAS_W*CANVAS_H-1:0]  o_canvas
);

   localparam int CX_W    = $clog2(CANVAS_W);
   localparam int CY_W    = $clog2(CANVAS_H);
   localparam int N_CELLS = CANVAS_W * CANVAS_H;
   localparam int IDX_W   = $clog2(N_CELLS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CELLS - 1);

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [N_CELLS-1:0]   canvas_q, canvas_d;
   logic                 done_q, done_d;

   logic                 mouse_en;
   logic [CX_W-1:0]      cur_x, cur_x_nxt;
   logic [CY_W-1:0]      cur_y, cur_y_nxt;
   logic [N_CELLS-1:0]   brush_mask;

   // Motion is only honoured while drawing; a clear in the same cycle wins.
   assign mouse_en = i_mouse_valid && (state_q == ST_DRAW) && !i_clear;

   mouse_axis_accum #(
      .N           (CANVAS_W),
      .SCALE_SHIFT (SCALE_SHIFT),
      .INVERT      (0)
   ) u_axis_x (
      .clk           (clk),
      .rst           (rst),
      .i_en          (mouse_en),
      .i_delta       (i_move_x),
      .o_cursor      (cur_x),
      .o_cursor_next (cur_x_nxt)
   );

   mouse_axis_accum #(
      .N           (CANVAS_H),
      .SCALE_SHIFT (SCALE_SHIFT),
      .INVERT      (1)
   ) u_axis_y (
      .clk           (clk),
      .rst           (rst),
      .i_en          (mouse_en),
      .i_delta       (i_move_y),
      .o_cursor      (cur_y),
      .o_cursor_next (cur_y_nxt)
   );

   // Brush footprint around the cursor position being loaded this edge.
   // Each cell decides whether it is the centre or a neighbour; neighbour
   // terms for cells on the canvas edge are removed at elaboration time, so
   // clipping is implicit and a row never wraps into the next one.
   for (genvar gy = 0; gy < CANVAS_H; gy++) begin : g_row
      for (genvar gx = 0; gx < CANVAS_W; gx++) begin : g_col
         logic hit_c;
         logic hit_n;

         assign hit_c = (cur_x_nxt == CX_W'(gx)) && (cur_y_nxt == CY_W'(gy));

         if (BRUSH_PLUS == BRUSH_SHAPE_PLUS) begin : g_plus
            localparam bit HAS_L = (gx > 0);
            localparam bit HAS_R = (gx + 1 < CANVAS_W);
            localparam bit HAS_U = (gy > 0);
            localparam bit HAS_D = (gy + 1 < CANVAS_H);
            logic same_row, same_col;
            assign same_row = (cur_y_nxt == CY_W'(gy));
            assign same_col = (cur_x_nxt == CX_W'(gx));
            assign hit_n =
               (same_row && ((HAS_L && (cur_x_nxt == CX_W'(gx - 1))) ||
                             (HAS_R && (cur_x_nxt == CX_W'(gx + 1))))) ||
               (same_col && ((HAS_U && (cur_y_nxt == CY_W'(gy - 1))) ||
                             (HAS_D && (cur_y_nxt == CY_W'(gy + 1)))));
         end else begin : g_single
            assign hit_n = 1'b0;
         end

         assign brush_mask[cell_index(gx, gy, CANVAS_W)] = hit_c | hit_n;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      canvas_d = canvas_q;
      done_d   = 1'b0;

      if (i_clear) begin
         canvas_d = '0;
         state_d  = ST_DRAW;
         idx_d    = '0;
      end else begin
         case (state_q)
            ST_DRAW: begin
               if (mouse_en && i_lmb) begin
                  canvas_d = canvas_q | brush_mask;
               end else if (mouse_en && i_rmb) begin
                  canvas_d = canvas_q & ~brush_mask;
               end
               if (i_submit) begin
                  state_d = ST_STREAM;
                  idx_d   = '0;
               end
            end
            ST_STREAM: begin
               if (i_pixel_ready) begin
                  if (idx_q == IDX_LAST) begin
                     state_d = ST_DRAW;
                     idx_d   = '0;
                     done_d  = 1'b1;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
            default: begin
               state_d = ST_DRAW;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_DRAW;
         idx_q    <= '0;
         canvas_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         canvas_q <= canvas_d;
         done_q   <= done_d;
      end
   end

   // Pixel comes straight from the held index; the canvas is frozen while
   // streaming (only a clear can touch it, and that also drops valid).
   assign o_pixel       = ((state_q == ST_STREAM) && canvas_q[idx_q]) ? '1 : '0;
   assign o_pixel_valid = (state_q == ST_STREAM);
   assign o_busy        = (state_q == ST_STREAM);
   assign o_stream_done = done_q;
   assign o_cursor_x    = cur_x;
   assign o_cursor_y    = cur_y;
   assign o_canvas      = canvas_q;

endmodule
`default_nettype wire

// File: tb/tb_handwrite_canvas.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : tb_handwrite_canvas                                          |
// | Purpose  : Self-checking bench for handwrite_canvas. Two instances share |
// |            stimulus: single-cell brush (dut) and plus brush (dut_p).     |
// |            Streamed pixels are checked through an expected-pixel queue.  |
// | Revision : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
module tb_handwrite_canvas;

   localparam int W  = 30;
   localparam int H  = 30;
   localparam int NC = W * H;

   logic           clk = 1'b0;
   logic           rst;
   logic           i_mouse_valid, i_lmb, i_rmb, i_clear, i_submit, i_pixel_ready;
   logic [8:0]     i_move_x, i_move_y;

   logic [7:0]     o_pixel, p_pixel;
   logic           o_pixel_valid, o_stream_done, o_busy;
   logic           p_pixel_valid, p_stream_done, p_busy;
   logic [4:0]     o_cursor_x, o_cursor_y, p_cursor_x, p_cursor_y;
   logic [NC-1:0]  o_canvas, p_canvas;

   always #5 clk = ~clk;

   handwrite_canvas #(.CANVAS_W(W), .CANVAS_H(H), .SCALE_SHIFT(2), .PIXEL_W(8), .BRUSH_PLUS(0)) dut (
      .clk(clk), .rst(rst), .i_mouse_valid(i_mouse_valid), .i_move_x(i_move_x), .i_move_y(i_move_y),
      .i_lmb(i_lmb), .i_rmb(i_rmb), .i_clear(i_clear), .i_submit(i_submit), .i_pixel_ready(i_pixel_ready),
      .o_pixel(o_pixel), .o_pixel_valid(o_pixel_valid), .o_stream_done(o_stream_done), .o_busy(o_busy),
      .o_cursor_x(o_cursor_x), .o_cursor_y(o_cursor_y), .o_canvas(o_canvas));

   handwrite_canvas #(.CANVAS_W(W), .CANVAS_H(H), .SCALE_SHIFT(2), .PIXEL_W(8), .BRUSH_PLUS(1)) dut_p (
      .clk(clk), .rst(rst), .i_mouse_valid(i_mouse_valid), .i_move_x(i_move_x), .i_move_y(i_move_y),
      .i_lmb(i_lmb), .i_rmb(i_rmb), .i_clear(i_clear), .i_submit(i_submit), .i_pixel_ready(i_pixel_ready),
      .o_pixel(p_pixel), .o_pixel_valid(p_pixel_valid), .o_stream_done(p_stream_done), .o_busy(p_busy),
      .o_cursor_x(p_cursor_x), .o_cursor_y(p_cursor_y), .o_canvas(p_canvas));

   int         errors = 0;
   int         checks = 0;
   logic [7:0] sb[$];
   int         n_acc  = 0;
   int         n_done = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_cv(input string name, input logic [NC-1:0] act, input logic [NC-1:0] exp);
      int first;
      checks++;
      if (act !== exp) begin
         first = 0;
         for (int i = NC - 1; i >= 0; i--) if (act[i] !== exp[i]) first = i;
         errors++;
         $display("FAIL %s: bit %0d is %b expected %b", name, first, act[first], exp[first]);
      end
   endtask

   // Build a bitmap with up to five set bits; -1 means unused.
   function automatic logic [NC-1:0] bm(input int a, input int b, input int c, input int d, input int e);
      logic [NC-1:0] v;
      v = '0;
      if (a >= 0) v[a] = 1'b1;
      if (b >= 0) v[b] = 1'b1;
      if (c >= 0) v[c] = 1'b1;
      if (d >= 0) v[d] = 1'b1;
      if (e >= 0) v[e] = 1'b1;
      return v;
   endfunction

   // Monitor: samples 1 time unit after each falling edge, i.e. with the
   // ready value that the next rising edge will see.
   initial begin : monitor
      logic       hold;
      logic [7:0] hold_pix;
      logic [7:0] exp_pix;
      hold = 1'b0;
      hold_pix = '0;
      forever begin
         @(negedge clk);
         #1;
         if (o_stream_done) n_done++;
         if (o_pixel_valid) begin
            if (hold) begin
               checks++;
               if (o_pixel !== hold_pix) begin
                  errors++;
                  $display("FAIL pixel_stable: got %0h expected %0h", o_pixel, hold_pix);
               end
            end
            hold     = !i_pixel_ready;
            hold_pix = o_pixel;
            if (i_pixel_ready) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL sb_underflow: got unexpected pixel %0h expected none", o_pixel);
               end else begin
                  exp_pix = sb.pop_front();
                  if (o_pixel !== exp_pix) begin
                     errors++;
                     $display("FAIL pixel[%0d]: got %0h expected %0h", n_acc, o_pixel, exp_pix);
                  end
                  n_acc++;
               end
            end
         end else begin
            hold = 1'b0;
         end
      end
   end

   task automatic strobe(input logic [8:0] dx, input logic [8:0] dy, input logic l, input logic r);
      @(negedge clk);
      i_mouse_valid = 1'b1;
      i_move_x = dx;
      i_move_y = dy;
      i_lmb = l;
      i_rmb = r;
      @(negedge clk);
      i_mouse_valid = 1'b0;
      i_lmb = 1'b0;
      i_rmb = 1'b0;
      i_move_x = '0;
      i_move_y = '0;
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      i_clear = 1'b1;
      @(negedge clk);
      i_clear = 1'b0;
   endtask

   initial begin : stim
      int k;
      bit fin;
      rst = 1'b1;
      i_mouse_valid = 0; i_lmb = 0; i_rmb = 0; i_clear = 0; i_submit = 0; i_pixel_ready = 0;
      i_move_x = '0; i_move_y = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("rst_cursor_x", o_cursor_x, 15);
      chk("rst_cursor_y", o_cursor_y, 15);
      chk_cv("rst_canvas", o_canvas, '0);
      chk("rst_valid", o_pixel_valid, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_pixel", o_pixel, 0);
      chk("rst_done", o_stream_done, 0);

      // Paint right by 8 counts = 2 cells -> (17,15), bit 467
      strobe(9'd8, 9'd0, 1'b1, 1'b0);
      chk("move_x", o_cursor_x, 17);
      chk("move_y", o_cursor_y, 15);
      chk_cv("paint_single", o_canvas, bm(467, -1, -1, -1, -1));
      chk_cv("paint_plus_mid", p_canvas, bm(467, 466, 468, 437, 497));

      // Erase in place
      strobe(9'd0, 9'd0, 1'b0, 1'b1);
      chk_cv("erase_single", o_canvas, '0);
      chk_cv("erase_plus", p_canvas, '0);

      // Clamp to top-left, then bottom-right
      strobe(9'h100, 9'd255, 1'b0, 1'b0);
      chk("clamp_lo_x", o_cursor_x, 0);
      chk("clamp_lo_y", o_cursor_y, 0);
      chk_cv("move_only", o_canvas, '0);
      strobe(9'd255, 9'h100, 1'b0, 1'b0);
      chk("clamp_hi_x", o_cursor_x, 29);
      chk("clamp_hi_y", o_cursor_y, 29);

      // Plus brush clipped at (0,0)
      strobe(9'h100, 9'd255, 1'b1, 1'b0);
      chk_cv("corner_single", o_canvas, bm(0, -1, -1, -1, -1));
      chk_cv("corner_plus", p_canvas, bm(0, 1, 30, -1, -1));

      pulse_clear();
      chk_cv("clear_canvas", o_canvas, '0);
      chk_cv("clear_canvas_p", p_canvas, '0);
      chk("clear_keeps_x", o_cursor_x, 0);

      // Plus brush at (29,0): no wrap into row 1 col 0
      strobe(9'd255, 9'd0, 1'b1, 1'b0);
      chk("edge_x", o_cursor_x, 29);
      chk("edge_y", o_cursor_y, 0);
      chk_cv("edge_single", o_canvas, bm(29, -1, -1, -1, -1));
      chk_cv("edge_plus", p_canvas, bm(28, 29, 59, -1, -1));

      // Bits 0 and 899 for the stream
      pulse_clear();
      strobe(9'h100, 9'd0, 1'b1, 1'b0);
      strobe(9'd255, 9'h100, 1'b1, 1'b0);
      chk_cv("pattern", o_canvas, bm(0, 899, -1, -1, -1));

      // Full stream with ready toggling 1,0,1,0 and mouse activity ignored
      @(negedge clk);
      i_submit = 1'b1;
      for (int i = 0; i < NC; i++) sb.push_back((i == 0 || i == NC - 1) ? 8'hFF : 8'h00);
      n_acc = 0;
      @(negedge clk);
      i_submit = 1'b0;
      chk("stream_valid", o_pixel_valid, 1);
      chk("stream_busy", o_busy, 1);
      k = 0;
      fin = 1'b0;
      while (k < 3000 && !fin) begin
         i_pixel_ready = (k % 2 == 0);
         i_mouse_valid = (k == 5 || k == 6);
         i_move_x = 9'h19C;
         i_lmb = (k == 5);
         i_rmb = (k == 6);
         #2;
         if (sb.size() == 0) fin = 1'b1;
         k++;
         @(negedge clk);
      end
      i_mouse_valid = 1'b0; i_lmb = 1'b0; i_rmb = 1'b0; i_move_x = '0; i_pixel_ready = 1'b0;
      chk("stream_finished", int'(fin), 1);
      chk("accepts", n_acc, NC);
      chk("done_pulse", o_stream_done, 1);
      chk("done_valid_low", o_pixel_valid, 0);
      chk("done_busy_low", o_busy, 0);
      @(negedge clk);
      chk("done_one_cycle", o_stream_done, 0);
      chk("done_count", n_done, 1);
      chk("stream_no_move_x", o_cursor_x, 29);
      chk("stream_no_move_y", o_cursor_y, 29);
      chk_cv("stream_no_paint", o_canvas, bm(0, 899, -1, -1, -1));

      // Clear after 100 accepted pixels
      @(negedge clk);
      i_submit = 1'b1;
      for (int i = 0; i < NC; i++) sb.push_back((i == 0 || i == NC - 1) ? 8'hFF : 8'h00);
      n_acc = 0;
      @(negedge clk);
      i_submit = 1'b0;
      k = 0;
      while (k < 2000) begin
         if (n_acc >= 100) begin
            i_pixel_ready = 1'b0;
            i_clear = 1'b1;
            break;
         end
         i_pixel_ready = 1'b1;
         @(negedge clk);
         k++;
      end
      chk("accepts_before_clear", n_acc, 100);
      @(negedge clk);
      i_clear = 1'b0;
      sb.delete();
      chk("clr_valid", o_pixel_valid, 0);
      chk("clr_busy", o_busy, 0);
      chk("clr_done", o_stream_done, 0);
      chk_cv("clr_canvas", o_canvas, '0);
      @(negedge clk);
      chk("clr_valid_hold", o_pixel_valid, 0);
      chk("clr_no_done", n_done, 1);

      // Clear and submit together: no stream starts
      @(negedge clk);
      i_clear = 1'b1;
      i_submit = 1'b1;
      @(negedge clk);
      i_clear = 1'b0;
      i_submit = 1'b0;
      chk("clr_sub_busy", o_busy, 0);
      chk("clr_sub_valid", o_pixel_valid, 0);
      @(negedge clk);
      chk("clr_sub_valid2", o_pixel_valid, 0);
      chk("final_done_count", n_done, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
